// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and defaults for the digital clock mode sequencer.
// Holds the mode_t encoding, default timing parameters and the clock's
// seconds/hours moduli used by the counter datapath.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    T_HRS = 3'd1,
    T_MIN = 3'd2,
    A_HRS = 3'd3,
    A_MIN = 3'd4
  } mode_t;

  localparam int REPEAT_DLY_DEF = 3;
  localparam int TIMEOUT_DEF    = 10;

  localparam int NS = 60;
  localparam int NH = 24;

  // Mode button cycle: RUN -> set hours -> set minutes -> alarm hours -> alarm minutes -> RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     return T_HRS;
      T_HRS:   return T_MIN;
      T_MIN:   return A_HRS;
      A_HRS:   return A_MIN;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Button and control-level bundle between the raw buttons, the mode
// sequencer and the clock/alarm counter datapath.
// master drives the buttons; slave is the sequencer.
interface clock_mode_ctrl_if;

  logic       Mode;
  logic       Adv;
  logic       Timeset;
  logic       Alarmset;
  logic       Hrsadv;
  logic       Minadv;
  logic       Alarmon;
  logic [2:0] ModeState;

  modport master (
    output Mode, Adv,
    input  Timeset, Alarmset, Hrsadv, Minadv, Alarmon, ModeState
  );

  modport slave (
    input  Mode, Adv,
    output Timeset, Alarmset, Hrsadv, Minadv, Alarmon, ModeState
  );

endinterface

// File: rtl/clock_mode_ctrl_btn_rep.sv
// Button press detector with auto-repeat.
// press: button high this edge, low the previous edge.
// rep:   button still held after an accepted press and the hold counter has
//        reached REPEAT_DLY, so a strobe is due every cycle.
// clr (a Mode press) discards the current hold; the button must be released
// and pressed again before repeats resume.
module btn_rep #(
  parameter int REPEAT_DLY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clr,
  output logic press,
  output logic rep
);

  localparam int CW = $clog2(REPEAT_DLY + 1);
  localparam logic [CW-1:0] SAT = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] TH  = CW'(REPEAT_DLY - 1);

  logic          btn_q;
  logic          armed;
  logic [CW-1:0] hold_cnt;

  assign press = btn & ~btn_q;
  // The counter lands on SAT at the edge where hold_cnt == TH, so that edge already repeats.
  assign rep   = btn & ~press & ~clr & armed & (hold_cnt >= TH);

  // Edge history, saturating hold counter, and the armed flag that survives only an uninterrupted hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= 1'b0;
      hold_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      btn_q <= btn;
      if (clr || !btn || press)
        hold_cnt <= '0;
      else if (hold_cnt != SAT)
        hold_cnt <= hold_cnt + CW'(1);
      if (clr || !btn)
        armed <= 1'b0;
      else if (press)
        armed <= 1'b1;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Two-button mode sequencer for the digital clock.
// Mode steps RUN -> T_HRS -> T_MIN -> A_HRS -> A_MIN -> RUN; Adv issues
// hour/minute advance strobes in the set states (with auto-repeat) and
// toggles Alarmon in RUN. All outputs are registers or register decodes.
// Optional feature macro: MODE_TIMEOUT_EN adds an idle timeout that returns
// a set state to RUN after TIMEOUT idle edges.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               Pulse,
  input  logic               Reset,
  clock_mode_ctrl_if.slave   bus
);

  mode_t state, state_nxt;
  logic  mode_q;
  logic  mode_press;
  logic  adv_press;
  logic  adv_rep;
  logic  adv_hit;
  logic  timeout_hit;
  logic  hrs_adv, hrs_nxt;
  logic  min_adv, min_nxt;
  logic  alarm_on, alarm_nxt;

  assign mode_press = bus.Mode & ~mode_q;
  assign adv_hit    = (adv_press | adv_rep) & ~mode_press;

  btn_rep #(.REPEAT_DLY(REPEAT_DLY)) u_adv_rep (
    .clk   (Pulse),
    .rst   (Reset),
    .btn   (bus.Adv),
    .clr   (mode_press),
    .press (adv_press),
    .rep   (adv_rep)
  );

`ifdef MODE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_cnt;

  assign timeout_hit = (state != RUN) & ~mode_press & ~bus.Adv & (idle_cnt == IDLE_MAX);

  // Idle edge counter for set states; any button activity or landing in RUN restarts it.
  always_ff @(posedge Pulse) begin
    if (Reset)
      idle_cnt <= '0;
    else if (state_nxt == RUN || mode_press || bus.Adv)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + IW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State, Mode edge history and registered output levels.
  always_ff @(posedge Pulse) begin
    if (Reset) begin
      state    <= RUN;
      mode_q   <= 1'b0;
      hrs_adv  <= 1'b0;
      min_adv  <= 1'b0;
      alarm_on <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_q   <= bus.Mode;
      hrs_adv  <= hrs_nxt;
      min_adv  <= min_nxt;
      alarm_on <= alarm_nxt;
    end
  end

  // Next state and next strobes: Mode beats Adv, unused encodings fall back to RUN.
  always_comb begin
    state_nxt = state;
    hrs_nxt   = 1'b0;
    min_nxt   = 1'b0;
    alarm_nxt = alarm_on;
    case (state)
      RUN, T_HRS, T_MIN, A_HRS, A_MIN: begin
        if (mode_press)
          state_nxt = next_mode(state);
        else if (timeout_hit)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (state == RUN && adv_press && !mode_press)
      alarm_nxt = ~alarm_on;
    if (state == T_HRS || state == A_HRS)
      hrs_nxt = adv_hit;
    if (state == T_MIN || state == A_MIN)
      min_nxt = adv_hit;
  end

  assign bus.Timeset   = (state == T_HRS) || (state == T_MIN);
  assign bus.Alarmset  = (state == A_HRS) || (state == A_MIN);
  assign bus.Hrsadv    = hrs_adv;
  assign bus.Minadv    = min_adv;
  assign bus.Alarmon   = alarm_on;
  assign bus.ModeState = state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl (REPEAT_DLY=3, TIMEOUT=10).
// A vector table of {Reset, Mode, Adv, expected outputs} is applied one edge
// per row; hand-written sequences cover long holds and the idle timeout
// (MODE_TIMEOUT_EN) or its absence.
module tb_clock_mode_ctrl;
  import clock_pkg::*;

  logic Pulse = 1'b0;
  logic Reset = 1'b1;

  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(.REPEAT_DLY(3), .TIMEOUT(10)) dut (
    .Pulse (Pulse),
    .Reset (Reset),
    .bus   (bus)
  );

  // Free-running one-per-second clock, scaled down.
  always #5 Pulse = ~Pulse;

  typedef struct {
    logic       rst;
    logic       mode;
    logic       adv;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   check_count = 0;
  int   error_count = 0;

  // Expected output word {Timeset, Alarmset, Hrsadv, Minadv, Alarmon, ModeState}.
  function automatic logic [7:0] ex(input int ms, input bit ha, input bit ma, input bit al);
    logic ts, as_;
    ts  = (ms == 1) || (ms == 2);
    as_ = (ms == 3) || (ms == 4);
    return {ts, as_, ha, ma, al, 3'(ms)};
  endfunction

  task automatic addVec(input logic r, input logic m, input logic a, input logic [7:0] e);
    vecs.push_back('{rst: r, mode: m, adv: a, exp_out: e});
  endtask

  task automatic applyStimulus(input logic r, input logic m, input logic a);
    Reset    = r;
    bus.Mode = m;
    bus.Adv  = a;
    @(posedge Pulse);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_out);
    logic [7:0] act;
    act = {bus.Timeset, bus.Alarmset, bus.Hrsadv, bus.Minadv, bus.Alarmon, bus.ModeState};
    check_count++;
    if (act !== exp_out) begin
      error_count++;
      $display("[TB] FAIL %s actual=%b expected=%b (ts,as,ha,ma,al,ms)", name, act, exp_out);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp_val);
    check_count++;
    if (act != exp_val) begin
      error_count++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp_val);
    end
  endtask

  initial begin
    int hrs_seen;
    int min_seen;
    bus.Mode = 1'b0;
    bus.Adv  = 1'b0;

    // Reset and idle
    addVec(1, 0, 0, ex(0, 0, 0, 0));
    addVec(1, 0, 0, ex(0, 0, 0, 0));
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, ex(0, 0, 0, 0));

    // Mode sweep through all five states
    addVec(0, 1, 0, ex(1, 0, 0, 0)); addVec(0, 0, 0, ex(1, 0, 0, 0));
    addVec(0, 1, 0, ex(2, 0, 0, 0)); addVec(0, 0, 0, ex(2, 0, 0, 0));
    addVec(0, 1, 0, ex(3, 0, 0, 0)); addVec(0, 0, 0, ex(3, 0, 0, 0));
    addVec(0, 1, 0, ex(4, 0, 0, 0)); addVec(0, 0, 0, ex(4, 0, 0, 0));
    addVec(0, 1, 0, ex(0, 0, 0, 0)); addVec(0, 0, 0, ex(0, 0, 0, 0));

    // RUN: two presses toggle Alarmon 0->1->0
    addVec(0, 0, 1, ex(0, 0, 0, 1)); addVec(0, 0, 0, ex(0, 0, 0, 1));
    addVec(0, 0, 1, ex(0, 0, 0, 0)); addVec(0, 0, 0, ex(0, 0, 0, 0));

    // RUN: a long hold toggles once, no repeat
    addVec(0, 0, 1, ex(0, 0, 0, 1));
    for (int i = 0; i < 5; i++) addVec(0, 0, 1, ex(0, 0, 0, 1));
    addVec(0, 0, 0, ex(0, 0, 0, 1));
    addVec(0, 0, 1, ex(0, 0, 0, 0)); addVec(0, 0, 0, ex(0, 0, 0, 0));

    // To T_MIN, single Minadv strobe
    addVec(0, 1, 0, ex(1, 0, 0, 0)); addVec(0, 0, 0, ex(1, 0, 0, 0));
    addVec(0, 1, 0, ex(2, 0, 0, 0)); addVec(0, 0, 0, ex(2, 0, 0, 0));
    addVec(0, 0, 1, ex(2, 0, 1, 0));
    addVec(0, 0, 0, ex(2, 0, 0, 0)); addVec(0, 0, 0, ex(2, 0, 0, 0));

    // To A_HRS, Adv held 8 edges: strobes after k, k+3..k+7
    addVec(0, 1, 0, ex(3, 0, 0, 0)); addVec(0, 0, 0, ex(3, 0, 0, 0));
    addVec(0, 0, 1, ex(3, 1, 0, 0));
    addVec(0, 0, 1, ex(3, 0, 0, 0));
    addVec(0, 0, 1, ex(3, 0, 0, 0));
    for (int i = 0; i < 5; i++) addVec(0, 0, 1, ex(3, 1, 0, 0));
    addVec(0, 0, 0, ex(3, 0, 0, 0)); addVec(0, 0, 0, ex(3, 0, 0, 0));

    // A_MIN -> RUN -> T_HRS
    addVec(0, 1, 0, ex(4, 0, 0, 0)); addVec(0, 0, 0, ex(4, 0, 0, 0));
    addVec(0, 1, 0, ex(0, 0, 0, 0)); addVec(0, 0, 0, ex(0, 0, 0, 0));
    addVec(0, 1, 0, ex(1, 0, 0, 0)); addVec(0, 0, 0, ex(1, 0, 0, 0));

    // T_HRS: Mode and Adv together, Mode wins, held Adv stays dead until re-pressed
    addVec(0, 1, 1, ex(2, 0, 0, 0));
    for (int i = 0; i < 5; i++) addVec(0, 0, 1, ex(2, 0, 0, 0));
    addVec(0, 0, 0, ex(2, 0, 0, 0));
    addVec(0, 0, 1, ex(2, 0, 1, 0)); addVec(0, 0, 0, ex(2, 0, 0, 0));

    // T_MIN: repeating, then Mode while held -> no strobe, dead hold in A_HRS
    addVec(0, 0, 1, ex(2, 0, 1, 0));
    addVec(0, 0, 1, ex(2, 0, 0, 0));
    addVec(0, 0, 1, ex(2, 0, 0, 0));
    addVec(0, 0, 1, ex(2, 0, 1, 0));
    addVec(0, 0, 1, ex(2, 0, 1, 0));
    addVec(0, 1, 1, ex(3, 0, 0, 0));
    for (int i = 0; i < 4; i++) addVec(0, 0, 1, ex(3, 0, 0, 0));
    addVec(0, 0, 0, ex(3, 0, 0, 0));
    addVec(0, 0, 1, ex(3, 1, 0, 0)); addVec(0, 0, 0, ex(3, 0, 0, 0));

    // Back to RUN and set Alarmon
    addVec(0, 1, 0, ex(4, 0, 0, 0)); addVec(0, 0, 0, ex(4, 0, 0, 0));
    addVec(0, 1, 0, ex(0, 0, 0, 0)); addVec(0, 0, 0, ex(0, 0, 0, 0));
    addVec(0, 0, 1, ex(0, 0, 0, 1)); addVec(0, 0, 0, ex(0, 0, 0, 1));

    // T_MIN repeat with Alarmon set, then reset mid-repeat
    addVec(0, 1, 0, ex(1, 0, 0, 1)); addVec(0, 0, 0, ex(1, 0, 0, 1));
    addVec(0, 1, 0, ex(2, 0, 0, 1)); addVec(0, 0, 0, ex(2, 0, 0, 1));
    addVec(0, 0, 1, ex(2, 0, 1, 1));
    addVec(0, 0, 1, ex(2, 0, 0, 1));
    addVec(0, 0, 1, ex(2, 0, 0, 1));
    addVec(0, 0, 1, ex(2, 0, 1, 1));
    addVec(1, 0, 1, ex(0, 0, 0, 0));
    addVec(0, 0, 0, ex(0, 0, 0, 0)); addVec(0, 0, 0, ex(0, 0, 0, 0));

    // Mode still works after reset: into T_HRS
    addVec(0, 1, 0, ex(1, 0, 0, 0)); addVec(0, 0, 0, ex(1, 0, 0, 0));

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].mode, vecs[i].adv);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_out);
    end

    // Long hold in T_HRS: 20 edges held gives strobes at k and k+3..k+19
    hrs_seen = 0;
    min_seen = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1);
      if (bus.Hrsadv) hrs_seen++;
      if (bus.Minadv) min_seen++;
    end
    applyStimulus(0, 0, 0);
    if (bus.Hrsadv) hrs_seen++;
    checkValue("long_hold_hrsadv_count", hrs_seen, 18);
    checkValue("long_hold_minadv_count", min_seen, 0);

`ifdef MODE_TIMEOUT_EN
    // Timeout: fresh entry to T_HRS, 10 idle edges return to RUN
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("to_enter", ex(1, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("to_idle%0d", i), ex(1, 0, 0, 0));
    end
    applyStimulus(0, 0, 0);
    checkOutput("to_expire", ex(0, 0, 0, 0));

    // Adv press at idle count 7 restarts the count
    applyStimulus(0, 1, 0);
    checkOutput("to2_enter", ex(1, 0, 0, 0));
    for (int i = 1; i <= 7; i++) applyStimulus(0, 0, 0);
    checkOutput("to2_idle7", ex(1, 0, 0, 0));
    applyStimulus(0, 0, 1);
    checkOutput("to2_press", ex(1, 1, 0, 0));
    for (int i = 1; i <= 9; i++) applyStimulus(0, 0, 0);
    checkOutput("to2_idle9", ex(1, 0, 0, 0));
    applyStimulus(0, 0, 0);
    checkOutput("to2_expire", ex(0, 0, 0, 0));
`else
    // Without the timeout a set state persists through a long idle stretch
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0);
    checkOutput("no_timeout_persist", ex(1, 0, 0, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Two-button mode sequencer for the digital clock. It converts a Mode button and an Adv button into the Timeset, Alarmset, Minadv, Hrsadv and Alarmon control levels that drive the clock/alarm counter datapath. It cycles RUN → set hours → set minutes → alarm hours → alarm minutes → RUN, with edge-detected presses, auto-repeat on a held Adv, and an optional idle timeout back to RUN. It sits between the raw buttons and the top-level counter enables.

## Interface
- REPEAT_DLY, 3: Adv hold cycles after the press before auto-repeat starts; ≥1.
- TIMEOUT, 10: idle cycles in a set state before the forced return to RUN; ≥2. Used only with the timeout feature.
- Pulse  in  1  clock; one cycle per second.
- Reset  in  1  reset; synchronous, active-high.
- Mode  in  1  mode button level; already synchronous to Pulse.
- Adv  in  1  advance button level; already synchronous to Pulse.
- Timeset  out  1  high in T_HRS and T_MIN.
- Alarmset  out  1  high in A_HRS and A_MIN.
- Hrsadv  out  1  hours-advance strobe; only in T_HRS or A_HRS.
- Minadv  out  1  minutes-advance strobe; only in T_MIN or A_MIN.
- Alarmon  out  1  alarm-enable level; toggled from RUN.
- ModeState  out  3  current mode_t encoding, for display blinking.

## Operation
- States: RUN=0, T_HRS=1, T_MIN=2, A_HRS=3, A_MIN=4. Encodings 5–7 are unreachable and recover to RUN on the next edge.
- A Mode press is Mode=1 with a registered Mode_q=0. It advances the state RUN→T_HRS→T_MIN→A_HRS→A_MIN→RUN.
- An Adv press is Adv=1 with a registered Adv_q=0.
- Adv press in a set state: one advance strobe.
  - Hrsadv in *_HRS states, Minadv in *_MIN states.
- Adv press in RUN: toggles Alarmon. There is no auto-repeat in RUN.
- Auto-repeat: a hold counter clears on each Adv press and increments while Adv=1, saturating at REPEAT_DLY.
  - Once saturated with Adv still 1 in a set state, the strobe is asserted every cycle.
  - Adv=0 clears the counter and stops strobes.
- Simultaneous Mode and Adv presses: Mode wins. The Adv press is discarded, no strobe is issued, and the hold counter clears.
- A Mode press while Adv is held clears the hold counter. Adv must be released and pressed again before strobes resume in the new state.
- Exactly one or none of Timeset, Alarmset is high; they are never both high.
- At most one of Hrsadv, Minadv is high in any cycle.
- Reset (any time, including mid-repeat): state=RUN and all outputs 0 (Timeset, Alarmset, Hrsadv, Minadv, Alarmon, ModeState=0). Hold counter, idle counter, Mode_q and Adv_q are all cleared.

## Timing
- Edge k samples the inputs. All outputs are registers or decodes of registers; there are no combinational input-to-output paths.
- State change: a Mode press sampled at edge k makes Timeset, Alarmset and ModeState take their new values after edge k.
- Single strobe: an Adv press sampled at edge k makes Hrsadv/Minadv high from edge k to edge k+1, exactly one cycle. The datapath counter increments at edge k+1.
- Repeat strobes: with the press at edge k and Adv held, strobes follow edges k, k+REPEAT_DLY, k+REPEAT_DLY+1, … until Adv is sampled 0.
- Alarmon toggles after the edge that samples the press.
- Leaving a set state via Mode: no strobe is issued after that edge.

## Configuration
- MODE_TIMEOUT_EN defined:
  - An idle counter runs in set states.
  - It clears on any Mode press, on any edge where Adv=1, and on entry to RUN.
  - When it reaches TIMEOUT-1 and the next edge is also idle, the state forces to RUN at that edge. That is after TIMEOUT idle edges.
- MODE_TIMEOUT_EN undefined: no idle counter. Set states persist until Mode is pressed.

## Structure
- clock_pkg holds:
  - mode_t, a 3-bit enum RUN/T_HRS/T_MIN/A_HRS/A_MIN;
  - localparam defaults for REPEAT_DLY and TIMEOUT;
  - NS=60 and NH=24 for shared use.
- Sub-module btn_rep (one instance, for Adv): edge detect plus saturating hold counter.
  - Outputs: press and repeat.
  - Inputs: the button level, plus a clear input driven by a Mode press.
- The Mode edge detect is a single flop in the top of the block.

## Test plan
- Reset then idle 5 cycles → ModeState=0, all outputs 0. Mode pressed 5 times (1-cycle pulses, 1-cycle gaps) → ModeState 1,2,3,4,0, with Timeset high only for 1,2 and Alarmset high only for 3,4.
- In T_MIN, Adv high for 1 cycle at edge k → Minadv high exactly one cycle after edge k, Hrsadv stays 0.
- In A_HRS, Adv held 8 cycles with REPEAT_DLY=3 → 6 Hrsadv strobes, after edges k, k+3, k+4, k+5, k+6, k+7, and none after the release.
- In T_HRS, Mode and Adv rise on the same edge → state T_MIN, no strobe. Keep Adv held 5 more cycles → no Minadv until Adv is released and re-pressed.
- In RUN, Adv pressed twice → Alarmon 0→1→0, with Timeset/Alarmset/strobes stay 0. Reset asserted mid-repeat in T_MIN → all outputs 0 after that edge.
- With MODE_TIMEOUT_EN and TIMEOUT=10: enter T_HRS and idle 10 edges → ModeState=0 after the 10th. An Adv press at idle count 7 restarts the count, so RUN is entered 10 edges after the press.
